// File: rtl/dpll_seq.sv
// Bring-up and reconfiguration sequencer for digital_pll, clocked by the PLL reference.
// Owns all PLL control inputs and runs reset/settle timing around configuration changes.
module dpll_seq #(
  parameter int unsigned RST_CYC         = 5,
  parameter int unsigned SETTLE_CYC      = 10,
  parameter int unsigned TRIM_SETTLE_CYC = 5,
  parameter logic [4:0]  DIV_RST         = 5'd8
) (
  input  logic        osc,
  input  logic        reset,
  input  logic        en,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [4:0]  cfg_div,
  input  logic        cfg_dco,
  input  logic [25:0] cfg_trim,
  output logic        pll_enable,
  output logic        pll_resetb,
  output logic [4:0]  pll_div,
  output logic        pll_dco,
  output logic [25:0] pll_ext_trim,
  output logic        pll_ready,
  output logic        busy
);

  localparam logic [15:0] RST_LOAD    = 16'(RST_CYC - 1);
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] TRIM_LOAD   = 16'(TRIM_SETTLE_CYC - 1);

  typedef enum logic [1:0] {S_OFF, S_RST, S_SETTLE, S_RUN} state_t;

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next;
  logic        hs;
  logic        trim_only;

  assign cfg_ready = ((state == S_OFF) || (state == S_RUN)) && !reset;
  assign hs        = cfg_valid && cfg_ready;
  assign trim_only = cfg_dco && pll_dco && (cfg_div == pll_div);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_OFF: begin
        if (en) begin
          state_next = S_RST;
          cnt_next   = RST_LOAD;
        end
      end
      S_RST: begin
        if (!en) begin
          state_next = S_OFF;
        end else if (cnt == '0) begin
          state_next = S_SETTLE;
          cnt_next   = SETTLE_LOAD;
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      S_SETTLE: begin
        if (!en) begin
          state_next = S_OFF;
        end else if (cnt == '0) begin
          state_next = S_RUN;
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      S_RUN: begin
        if (!en) begin
          state_next = S_OFF;
        end else if (hs) begin
          if (trim_only) begin
            state_next = S_SETTLE;
            cnt_next   = TRIM_LOAD;
          end else begin
            state_next = S_RST;
            cnt_next   = RST_LOAD;
          end
        end
      end
      default: state_next = S_OFF;
    endcase
  end

  // Loading all three fields on a trim-only update is equivalent to loading trim
  // alone, since div and dco already match the request.
  always_ff @(posedge osc or posedge reset) begin
    if (reset) begin
      state        <= S_OFF;
      cnt          <= '0;
      pll_div      <= DIV_RST;
      pll_dco      <= 1'b0;
      pll_ext_trim <= '0;
      pll_enable   <= 1'b0;
      pll_resetb   <= 1'b0;
      pll_ready    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      pll_enable <= (state_next != S_OFF);
      pll_resetb <= (state_next == S_SETTLE) || (state_next == S_RUN);
      pll_ready  <= (state_next == S_RUN);
      busy       <= (state_next == S_RST) || (state_next == S_SETTLE);
      if (hs) begin
        pll_div      <= cfg_div;
        pll_dco      <= cfg_dco;
        pll_ext_trim <= cfg_trim;
      end
    end
  end

endmodule

// File: tb/tb_dpll_seq.sv
// Scoreboard bench for dpll_seq: a timestamp-based model predicts each cycle's outputs,
// a negedge monitor compares the DUT against the queued predictions.
module tb_dpll_seq;

  localparam int RC = 5;
  localparam int SC = 10;
  localparam int TC = 5;

  logic        osc = 1'b0;
  logic        reset;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [4:0]  cfg_div;
  logic        cfg_dco;
  logic [25:0] cfg_trim;
  logic        pll_enable;
  logic        pll_resetb;
  logic [4:0]  pll_div;
  logic        pll_dco;
  logic [25:0] pll_ext_trim;
  logic        pll_ready;
  logic        busy;

  dpll_seq #(.RST_CYC(RC), .SETTLE_CYC(SC), .TRIM_SETTLE_CYC(TC), .DIV_RST(5'd8)) dut (
    .osc(osc), .reset(reset), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_dco(cfg_dco), .cfg_trim(cfg_trim),
    .pll_enable(pll_enable), .pll_resetb(pll_resetb), .pll_div(pll_div),
    .pll_dco(pll_dco), .pll_ext_trim(pll_ext_trim), .pll_ready(pll_ready), .busy(busy)
  );

  always #5 osc = ~osc;

  typedef struct packed {
    logic        en;
    logic        rb;
    logic        rdy;
    logic        bsy;
    logic        crdy;
    logic [4:0]  div;
    logic        dco;
    logic [25:0] trim;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Model: PLL on/off plus the edge numbers at which resetb and ready next rise.
  bit          m_on  = 0;
  bit          m_rdy = 0;
  logic [4:0]  m_div = 5'd8;
  bit          m_dco = 0;
  logic [25:0] m_trim = '0;
  int          k = 0;
  int          t_rb = 0;
  int          t_rdy = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, want, $time);
    end
  endtask

  int mk = 0;
  always @(negedge osc) begin
    if (exp_q.size() > 0 && !reset) begin
      obs_t w, a;
      w = exp_q.pop_front();
      a = '{pll_enable, pll_resetb, pll_ready, busy, cfg_ready, pll_div, pll_dco, pll_ext_trim};
      chk($sformatf("edge%0d", mk), 64'(a), 64'(w));
      mk++;
    end
  end

  task automatic drive(input bit e, input bit v, input logic [4:0] d, input bit o,
                       input logic [25:0] t);
    obs_t x;
    bit   crdy, hs, trim_only, was_on;
    @(negedge osc);
    #1;
    en = e; cfg_valid = v; cfg_div = d; cfg_dco = o; cfg_trim = t;
    crdy      = !m_on || m_rdy;
    hs        = v && crdy;
    trim_only = hs && m_on && o && m_dco && (d == m_div);
    was_on    = m_on;
    if (hs) begin
      m_div = d; m_dco = o; m_trim = t;
    end
    if (!e) m_on = 0;
    else if (!was_on) begin
      m_on = 1; t_rb = k + RC; t_rdy = k + RC + SC;
    end else if (hs) begin
      if (trim_only) t_rdy = k + TC;
      else begin
        t_rb = k + RC; t_rdy = k + RC + SC;
      end
    end
    m_rdy  = m_on && (k >= t_rdy);
    x.en   = m_on;
    x.rb   = m_on && (k >= t_rb);
    x.rdy  = m_rdy;
    x.bsy  = m_on && !m_rdy;
    x.crdy = !m_on || m_rdy;
    x.div  = m_div;
    x.dco  = m_dco;
    x.trim = m_trim;
    exp_q.push_back(x);
    k++;
  endtask

  task automatic run(input int n, input bit e, input bit v, input logic [4:0] d,
                     input bit o, input logic [25:0] t);
    for (int i = 0; i < n; i++) drive(e, v, d, o, t);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_enable"}, 64'(pll_enable), 64'(0));
    chk({tag, "_resetb"}, 64'(pll_resetb), 64'(0));
    chk({tag, "_div"},    64'(pll_div), 64'(8));
    chk({tag, "_dco"},    64'(pll_dco), 64'(0));
    chk({tag, "_trim"},   64'(pll_ext_trim), 64'(0));
    chk({tag, "_ready"},  64'(pll_ready), 64'(0));
    chk({tag, "_busy"},   64'(busy), 64'(0));
    chk({tag, "_cfgrdy"}, 64'(cfg_ready), 64'(0));
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; cfg_valid = 1'b0;
    cfg_div = '0; cfg_dco = 1'b0; cfg_trim = '0;
    #2;
    chk_reset_vals("por");
    repeat (2) @(negedge osc);
    reset = 1'b0;

    run(16, 1, 0, 0, 0, 0);                    // default bring-up
    run(1, 1, 1, 5'd8, 1, 26'h0000123);        // dco change -> full reset
    run(16, 1, 0, 0, 0, 0);
    run(1, 1, 1, 5'd8, 1, 26'h00000FF);        // trim-only update
    run(6, 1, 0, 0, 0, 0);
    run(1, 1, 1, 5'd16, 0, 26'h0000055);       // divider change
    run(16, 1, 0, 0, 0, 0);
    run(1, 1, 1, 5'd16, 0, 26'h0000055);       // identical non-DCO -> full reset
    run(17, 1, 1, 5'd3, 0, 26'h0000AAA);       // held valid, taken on first RUN edge
    run(16, 1, 0, 0, 0, 0);
    run(1, 1, 1, 5'd8, 0, 26'h0);              // reconfig then abort in SETTLE
    run(7, 1, 0, 0, 0, 0);
    run(4, 0, 0, 0, 0, 0);
    run(16, 1, 0, 0, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      bit          e, v, o;
      logic [4:0]  d;
      logic [25:0] t;
      e = ($urandom_range(0, 99) >= 3);
      v = ($urandom_range(0, 99) < 25);
      d = ($urandom_range(0, 1) != 0) ? m_div : 5'($urandom);
      o = ($urandom_range(0, 3) != 0);
      t = 26'($urandom);
      drive(e, v, d, o, t);
    end

    run(3, 0, 0, 0, 0, 0);
    run(1, 0, 1, 5'd8, 1, 26'h00000FF);
    run(16, 1, 0, 0, 0, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge osc);
    chk("drain", 64'(exp_q.size()), 64'(0));

    @(negedge osc);
    chk("pre_rst_trim", 64'(pll_ext_trim), 64'(26'h00000FF));
    chk("pre_rst_ready", 64'(pll_ready), 64'(1));
    #3;
    reset = 1'b1;
    #1;
    chk_reset_vals("async");
    repeat (2) @(negedge osc);
    chk_reset_vals("held");
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dpll_seq.md
# dpll_seq

Bring-up and reconfiguration sequencer for `digital_pll`, clocked by the PLL reference clock `osc`. It owns every control input of the PLL: `enable`, `resetb`, `div`, `dco` and `ext_trim`. It runs the power-up reset/settle sequence and accepts new configurations over a valid/ready handshake. It tells downstream logic when `clockp` is usable, and applies trim-only changes without re-resetting the PLL.

## Interface
Parameters:
- `RST_CYC`, default 5: cycles `pll_resetb` is held low after enable (range 1..65535).
- `SETTLE_CYC`, default 10: settle cycles after a full reset before `pll_ready` (range 1..65535).
- `TRIM_SETTLE_CYC`, default 5: settle cycles after a trim-only update (range 1..65535).
- `DIV_RST`, default 8: reset value of `pll_div`.

Ports:
- `osc`  in  1  clock (PLL reference).
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  level request: PLL on.
- `cfg_valid`  in  1  new configuration offered.
- `cfg_ready`  out  1  configuration accepted this cycle if `cfg_valid`.
- `cfg_div`  in  5  requested divider.
- `cfg_dco`  in  1  requested DCO (open-loop trim) mode.
- `cfg_trim`  in  26  requested external trim.
- `pll_enable`  out  1  drives PLL `enable`.
- `pll_resetb`  out  1  drives PLL `resetb` (active-low).
- `pll_div`  out  5  drives PLL `div`.
- `pll_dco`  out  1  drives PLL `dco`.
- `pll_ext_trim`  out  26  drives PLL `ext_trim`.
- `pll_ready`  out  1  `clockp` is stable and usable.
- `busy`  out  1  sequence in progress (RST or SETTLE).

## Operation
- States: OFF, RST, SETTLE, RUN. A 16-bit down-counter `cnt` times RST and SETTLE.
- Outputs per state, all registered:
  - OFF: enable=0, resetb=0, ready=0.
  - RST: enable=1, resetb=0.
  - SETTLE: enable=1, resetb=1, ready=0.
  - RUN: enable=1, resetb=1, ready=1.
  - `busy` is 1 in RST and SETTLE only.
- `cfg_ready` = state is OFF or RUN, and `reset` is low. A handshake occurs when `cfg_valid & cfg_ready` is sampled at a rising edge.
- `cfg_valid` in RST or SETTLE is not accepted. No side effect; the requester holds it.
- OFF:
  - A handshake loads `pll_div`, `pll_dco` and `pll_ext_trim` directly.
  - `en`=1 goes to RST with `cnt`=RST_CYC-1. A config accepted in the same cycle is applied before enable rises.
- RST: `cnt`==0 goes to SETTLE with `cnt`=SETTLE_CYC-1; otherwise decrement.
- SETTLE: `cnt`==0 goes to RUN; otherwise decrement.
- RUN, on handshake:
  - Trim-only update, when `cfg_dco`==1, `pll_dco`==1 and `cfg_div`==`pll_div`: load `pll_ext_trim` only, go to SETTLE with `cnt`=TRIM_SETTLE_CYC-1. The PLL is not reset.
  - Any other change, including an identical non-DCO config: load all three fields, go to RST with `cnt`=RST_CYC-1.
- `en`=0 in RST, SETTLE or RUN goes to OFF at the next edge. `en` takes priority over the RUN handshake rules. A config accepted in that same RUN cycle is still latched; the resulting state is OFF.
- `reset` asserted in any state forces the reset values immediately, with no sequencing and no partial state retained.

## Timing
- Reset values: state OFF, `pll_enable`=0, `pll_resetb`=0, `pll_div`=DIV_RST, `pll_dco`=0, `pll_ext_trim`=0, `pll_ready`=0, `busy`=0, `cfg_ready`=0 while `reset` is high.
- Bring-up, with `en`=1 first sampled at edge E in OFF:
  - `pll_enable` rises after E.
  - `pll_resetb` rises after E+RST_CYC.
  - `pll_ready` rises after E+RST_CYC+SETTLE_CYC.
- Full reconfiguration, with handshake at edge H in RUN:
  - `pll_ready` and `pll_resetb` fall and new fields appear after H.
  - `pll_resetb` rises after H+RST_CYC.
  - `pll_ready` rises after H+RST_CYC+SETTLE_CYC.
- Trim-only update, with handshake at edge H: `pll_ready` falls and the new trim appears after H; `pll_ready` rises after H+TRIM_SETTLE_CYC. `pll_resetb` stays 1 throughout.
- `en` falling, sampled at edge F: all PLL controls and `pll_ready` go low after F. Config fields hold their values.
- `pll_*` config outputs change only on a handshake or reset, never mid-sequence.

## Test plan
- Defaults: reset, then `en`=1 at edge 0 → `pll_enable` rises after edge 0, `pll_resetb` after edge 5, `pll_ready` after edge 15; `div`=8, `dco`=0, trim=0.
- Trim-only update: in RUN with `dco`=1, `div`=8, handshake trim=26'h0000_0FF → resetb stays 1, ready low for exactly 5 cycles, `pll_ext_trim`=0FF.
- Divider change: in RUN, handshake `div`=16 → `pll_div`=16 and `pll_resetb` low for 5 cycles, ready low for 15 cycles.
- Busy rejection: `cfg_valid`=1 held through RST/SETTLE → `cfg_ready`=0 and no field change until RUN, then accepted on the first RUN edge.
- Abort: `en`=0 on the 3rd SETTLE cycle → OFF next edge, enable=0, resetb=0, ready=0. Re-raising `en` restarts the full 5+10 sequence.
- Async reset mid-RUN with trim=0FF → all outputs return to reset values immediately, trim=0, without waiting for an `osc` edge.
